decoder_2to4_simplified: RTL and testbench

2-to-4 one-hot decoder with a combinational output plus an optional registered, observable copy. The combinational path `out` depends only on `in`, so it decodes correctly even when `clk` is idle. The registered path adds a valid flag, a change pulse and per-code saturating hit counters for status and debug. It sits between a 2-bit select source and the four consumers it selects among.

---
 rtl/decoder_pkg.sv | 25 ++
 rtl/sat_counter.sv | 24 ++
 rtl/decoder_2to4_simplified.sv | 61 ++++++
 tb/tb_decoder_2to4_simplified.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the 2-to-4 decoder: default counter width,
// the one-hot code constants and the decode function used by both the
// combinational and registered paths.
package decoder_pkg;

    localparam int CNT_W_DEFAULT = 8;

    localparam logic [3:0] OH_CODE0 = 4'b0001;
    localparam logic [3:0] OH_CODE1 = 4'b0010;
    localparam logic [3:0] OH_CODE2 = 4'b0100;
    localparam logic [3:0] OH_CODE3 = 4'b1000;

    // Map a 2-bit select code onto its one-hot form.
    function automatic logic [3:0] onehot4(input logic [1:0] code);
        onehot4 = OH_CODE0;
        case (code)
            2'b00: onehot4 = OH_CODE0;
            2'b01: onehot4 = OH_CODE1;
            2'b10: onehot4 = OH_CODE2;
            2'b11: onehot4 = OH_CODE3;
            default: onehot4 = OH_CODE0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. The clear wins over a
// same-cycle increment and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count register: reset to zero, clear first, then saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_2to4_simplified.sv
// 2-to-4 one-hot decoder. The combinational output follows the select code
// at all times; a registered copy adds a valid flag, a change pulse and
// per-code saturating hit counters for status and debug.
module decoder_2to4_simplified
    import decoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         in,
    input  logic               en,
    input  logic               clr,
    output logic [3:0]         out,
    output logic [3:0]         out_q,
    output logic               out_vld,
    output logic               chg,
    output logic [4*CNT_W-1:0] cnt
);

    logic [3:0] dec;
    logic [3:0] inc;

    // Pure combinational decode, independent of clock, reset and enable.
    always_comb begin
        dec = onehot4(in);
        out = dec;
    end

    // Capture register; the change pulse only fires once a prior capture
    // exists, so the first capture after reset never flags a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= 4'b0000;
            out_vld <= 1'b0;
            chg     <= 1'b0;
        end else if (en) begin
            out_q   <= dec;
            out_vld <= 1'b1;
            chg     <= out_vld && (dec != out_q);
        end else begin
            chg     <= 1'b0;
        end
    end

    // One hit counter per code, bumped when that code is captured.
    for (genvar k = 0; k < 4; k++) begin : g_cnt
        assign inc[k] = en && (in == 2'(k));

        sat_counter #(
            .W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (inc[k]),
            .clr  (clr),
            .count(cnt[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_decoder_2to4_simplified.sv
// Directed bench for decoder_2to4_simplified with 3-bit counters so that
// saturation is reached quickly.
module tb_decoder_2to4_simplified;

    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic [1:0]    in;
    logic          en;
    logic          clr;
    logic [3:0]    out;
    logic [3:0]    out_q;
    logic          out_vld;
    logic          chg;
    logic [4*CW-1:0] cnt;

    logic clkRun;
    int   vectorCount;
    int   missCount;

    typedef struct {
        logic        en;
        logic        clr;
        logic [1:0]  in;
        logic [3:0]  expOut;
        logic [3:0]  expOutQ;
        logic        expVld;
        logic        expChg;
        logic [11:0] expCnt;
    } vecT;

    vecT vecs[14];

    decoder_2to4_simplified #(
        .CNT_W(CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .en     (en),
        .clr    (clr),
        .out    (out),
        .out_q  (out_q),
        .out_vld(out_vld),
        .chg    (chg),
        .cnt    (cnt)
    );

    // Gated clock so the first sweep can run with the clock idle.
    initial clk = 1'b0;
    always begin
        #5;
        if (clkRun) clk = ~clk;
    end

    // Hard stop in case anything stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Compare one value and log any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive inputs at a falling edge, then advance to the next falling edge.
    task automatic applyStimulus(input logic e, input logic c, input logic [1:0] code);
        en  = e;
        clr = c;
        in  = code;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Check every registered output at once.
    task automatic checkRegs(input string tag, input logic [3:0] q, input logic v,
                             input logic ch, input logic [11:0] c);
        checkOutput({tag, " out_q"}, 32'(out_q), 32'(q));
        checkOutput({tag, " out_vld"}, 32'(out_vld), 32'(v));
        checkOutput({tag, " chg"}, 32'(chg), 32'(ch));
        checkOutput({tag, " cnt"}, 32'(cnt), 32'(c));
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        clkRun      = 1'b0;
        rst_n       = 1'b0;
        en          = 1'b0;
        clr         = 1'b0;
        in          = 2'b00;

        //          en    clr   in     out      out_q    vld   chg   cnt {c3,c2,c1,c0}
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 4'b0001, 4'b0000, 1'b0, 1'b0, 12'b000_000_000_000};
        vecs[1]  = '{1'b1, 1'b0, 2'b10, 4'b0100, 4'b0100, 1'b1, 1'b0, 12'b000_001_000_000};
        vecs[2]  = '{1'b1, 1'b0, 2'b10, 4'b0100, 4'b0100, 1'b1, 1'b0, 12'b000_010_000_000};
        vecs[3]  = '{1'b1, 1'b0, 2'b01, 4'b0010, 4'b0010, 1'b1, 1'b1, 12'b000_010_001_000};
        vecs[4]  = '{1'b1, 1'b0, 2'b11, 4'b1000, 4'b1000, 1'b1, 1'b1, 12'b001_010_001_000};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 4'b0001, 4'b1000, 1'b1, 1'b0, 12'b001_010_001_000};
        vecs[6]  = '{1'b0, 1'b0, 2'b00, 4'b0001, 4'b1000, 1'b1, 1'b0, 12'b001_010_001_000};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 4'b0001, 4'b1000, 1'b1, 1'b0, 12'b001_010_001_000};
        vecs[8]  = '{1'b0, 1'b0, 2'b00, 4'b0001, 4'b1000, 1'b1, 1'b0, 12'b001_010_001_000};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 4'b0001, 4'b1000, 1'b1, 1'b0, 12'b001_010_001_000};
        vecs[10] = '{1'b1, 1'b0, 2'b11, 4'b1000, 4'b1000, 1'b1, 1'b0, 12'b010_010_001_000};
        vecs[11] = '{1'b1, 1'b1, 2'b00, 4'b0001, 4'b0001, 1'b1, 1'b1, 12'b000_000_000_000};
        vecs[12] = '{1'b0, 1'b1, 2'b10, 4'b0100, 4'b0001, 1'b1, 1'b0, 12'b000_000_000_000};
        vecs[13] = '{1'b1, 1'b0, 2'b00, 4'b0001, 4'b0001, 1'b1, 1'b0, 12'b000_000_000_001};

        // Combinational sweep with the clock idle and reset held.
        for (int i = 0; i < 4; i++) begin
            in = 2'(i);
            #10;
            checkOutput($sformatf("sweep out in=%0d", i), 32'(out), 32'(4'b0001 << i));
        end
        checkRegs("reset hold", 4'b0000, 1'b0, 1'b0, 12'd0);

        // Release reset while the clock is still idle, then start it.
        en    = 1'b0;
        in    = 2'b00;
        rst_n = 1'b1;
        #2;
        clkRun = 1'b1;
        @(negedge clk);

        // Table-driven main sequence.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].en, vecs[i].clr, vecs[i].in);
            checkOutput($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].expOut));
            checkRegs($sformatf("vec%0d", i), vecs[i].expOutQ, vecs[i].expVld,
                      vecs[i].expChg, vecs[i].expCnt);
        end

        // Clear with capture disabled: registered code holds, counters zero.
        applyStimulus(1'b0, 1'b1, 2'b00);
        checkRegs("clr only", 4'b0001, 1'b1, 1'b0, 12'd0);

        // Saturation: code 01 captured ten times, counter stops at 7.
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b0, 2'b01);
            checkRegs($sformatf("sat k=%0d", k), 4'b0010, 1'b1, (k == 1),
                      12'((k < 7 ? k : 7) << CW));
        end

        // Asynchronous reset mid-run, checked without any clock edge.
        en = 1'b1;
        in = 2'b10;
        #2;
        rst_n = 1'b0;
        #1;
        checkRegs("async reset", 4'b0000, 1'b0, 1'b0, 12'd0);
        checkOutput("async reset out", 32'(out), 32'(4'b0100));
        #1;
        rst_n = 1'b1;

        // First edge after release captures but never flags a change.
        @(posedge clk);
        @(negedge clk);
        checkRegs("post-reset capture", 4'b0100, 1'b1, 1'b0, 12'b000_001_000_000);

        applyStimulus(1'b1, 1'b0, 2'b11);
        checkRegs("post-reset change", 4'b1000, 1'b1, 1'b1, 12'b001_001_000_000);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
